// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: PENDING/ENABLE/MODE/ACTIVE registers,
// synchronised edge/level sources and a registered active-low CPU interrupt.
module irq_controller #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [15:0] BASE_ADDR = 16'h7010
) (
    input  logic               cpu_clk,
    input  logic               rst_ni,
    input  logic [15:0]        cpu_address_i,
    input  logic [7:0]         data_i,
    output logic [7:0]         data_o,
    output logic               data_en_o,
    input  logic               wen_ni,
    input  logic [NUM_IRQ-1:0] irq_src_i,
    output logic               irq_no
);
    localparam logic [7:0] IRQ_MASK = 8'((9'd1 << NUM_IRQ) - 9'd1);

    logic [7:0] src_ext;
    logic [7:0] s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [7:0] pend_q, pend_d, en_q, en_d, mode_q, mode_d;
    logic       irq_q, irq_d;
    logic       select, wr_en;
    logic [1:0] offset;
    logic [7:0] w1c, rise, hit, active, rd_data;
    logic [2:0] active_id;

    assign select = (cpu_address_i[15:2] == BASE_ADDR[15:2]);
    assign offset = cpu_address_i[1:0];
    assign wr_en  = select && !wen_ni;

    always_comb begin
        src_ext = '0;
        src_ext[NUM_IRQ-1:0] = irq_src_i;
    end

    always_comb begin
        s1_d = src_ext & IRQ_MASK;
        s2_d = s1_q;
        s3_d = s2_q;
        w1c  = (wr_en && offset == 2'd0) ? data_i : 8'h00;
        rise = s2_q & ~s3_q;
        // Edge bits latch until cleared (a coincident set wins); level bits follow s2.
        pend_d = ((mode_q & (rise | (pend_q & ~w1c))) | (~mode_q & s2_q)) & IRQ_MASK;
        en_d   = en_q;
        mode_d = mode_q;
        if (wr_en && offset == 2'd1) en_d   = data_i & IRQ_MASK;
        if (wr_en && offset == 2'd2) mode_d = data_i & IRQ_MASK;
        irq_d = ~|(pend_q & en_q);
    end

    always_comb begin
        hit       = pend_q & en_q;
        active_id = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hit[i]) active_id = 3'(i);
        end
        active = {|hit, 4'b0000, active_id};
    end

    always_comb begin
        case (offset)
            2'd0:    rd_data = pend_q;
            2'd1:    rd_data = en_q;
            2'd2:    rd_data = mode_q;
            default: rd_data = active;
        endcase
    end

    assign data_en_o = select && wen_ni;
    assign data_o    = data_en_o ? rd_data : 8'h00;
    assign irq_no    = irq_q;

    always_ff @(posedge cpu_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 8'h00;
            s2_q   <= 8'h00;
            s3_q   <= 8'h00;
            pend_q <= 8'h00;
            en_q   <= 8'h00;
            mode_q <= 8'h00;
            irq_q  <= 1'b1;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            s3_q   <= s3_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            mode_q <= mode_d;
            irq_q  <= irq_d;
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_irq_controller;
    localparam int          NUM_IRQ = 4;
    localparam logic [15:0] BASE    = 16'h7010;
    localparam logic [7:0]  MASK    = 8'h0F;

    logic               cpu_clk = 1'b0;
    logic               rst_ni  = 1'b0;
    logic [15:0]        cpu_address_i = 16'h0000;
    logic [7:0]         data_i  = 8'h00;
    logic [7:0]         data_o;
    logic               data_en_o;
    logic               wen_ni  = 1'b1;
    logic [NUM_IRQ-1:0] irq_src_i = '0;
    logic               irq_no;

    int n_checks = 0;
    int n_pass   = 0;

    irq_controller #(.NUM_IRQ(NUM_IRQ), .BASE_ADDR(BASE)) dut (
        .cpu_clk      (cpu_clk),
        .rst_ni       (rst_ni),
        .cpu_address_i(cpu_address_i),
        .data_i       (data_i),
        .data_o       (data_o),
        .data_en_o    (data_en_o),
        .wen_ni       (wen_ni),
        .irq_src_i    (irq_src_i),
        .irq_no       (irq_no)
    );

    always #5 cpu_clk = ~cpu_clk;

    // ---------------- behavioural model ----------------
    // hist[k] holds the source value sampled k+1 edges ago.
    logic [7:0] m_pend = 8'h00, m_en = 8'h00, m_mode = 8'h00;
    logic       m_irq  = 1'b1;
    logic [7:0] hist [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] m_src, m_nxt;
    logic       m_wr;

    always @(posedge cpu_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_pend = 8'h00; m_en = 8'h00; m_mode = 8'h00; m_irq = 1'b1;
            hist[0] = 8'h00; hist[1] = 8'h00; hist[2] = 8'h00;
        end else begin
            m_src = 8'h00;
            for (int i = 0; i < NUM_IRQ; i++) m_src[i] = irq_src_i[i];
            m_wr  = (cpu_address_i >= BASE) && (cpu_address_i <= BASE + 16'd3) && !wen_ni;
            m_irq = ((m_pend & m_en) == 8'h00);
            for (int i = 0; i < 8; i++) begin
                if (i >= NUM_IRQ) m_nxt[i] = 1'b0;
                else if (!m_mode[i]) m_nxt[i] = hist[1][i];
                else m_nxt[i] = (hist[1][i] && !hist[2][i]) ||
                                (m_pend[i] && !(m_wr && cpu_address_i == BASE && data_i[i]));
            end
            m_pend = m_nxt;
            if (m_wr && cpu_address_i == BASE + 16'd1) m_en   = data_i & MASK;
            if (m_wr && cpu_address_i == BASE + 16'd2) m_mode = data_i & MASK;
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = m_src;
        end
    end

    function automatic logic [7:0] m_read(input logic [15:0] addr);
        logic [7:0] h;
        h = m_pend & m_en;
        if (addr == BASE) return m_pend;
        if (addr == BASE + 16'd1) return m_en;
        if (addr == BASE + 16'd2) return m_mode;
        if (addr == BASE + 16'd3) begin
            for (int i = 0; i < 8; i++) if (h[i]) return 8'h80 | 8'(i);
            return 8'h00;
        end
        return 8'h00;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    endtask

    // Per-cycle compare against the model, away from the active edge.
    logic exp_en;
    always @(negedge cpu_clk) begin
        exp_en = (cpu_address_i >= BASE) && (cpu_address_i <= BASE + 16'd3) && wen_ni;
        check8("cyc_data_en_o", {7'd0, data_en_o}, {7'd0, exp_en});
        check8("cyc_data_o", data_o, exp_en ? m_read(cpu_address_i) : 8'h00);
        check8("cyc_irq_no", {7'd0, irq_no}, {7'd0, m_irq});
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic cpu_write(input logic [1:0] off, input logic [7:0] d);
        cpu_address_i = BASE + 16'(off);
        data_i = d;
        wen_ni = 1'b0;
        tick(1);
        wen_ni = 1'b1;
        cpu_address_i = 16'h0000;
    endtask

    task automatic read_at(input logic [15:0] addr, output logic [7:0] v, output logic en);
        cpu_address_i = addr;
        wen_ni = 1'b1;
        #1;
        v  = data_o;
        en = data_en_o;
    endtask

    task automatic check_reg(input string name, input logic [1:0] off, input logic [7:0] exp);
        logic [7:0] v;
        logic       en;
        read_at(BASE + 16'(off), v, en);
        check8(name, v, exp);
    endtask

    task automatic check_irq(input string name, input logic exp);
        check8(name, {7'd0, irq_no}, {7'd0, exp});
    endtask

    logic [7:0] rv;
    logic       ren;
    int         r;

    initial begin
        tick(2);
        check_irq("reset_irq_no", 1'b1);
        check_reg("reset_pending", 2'd0, 8'h00);
        check_reg("reset_active", 2'd3, 8'h00);
        rst_ni = 1'b1;
        tick(2);

        // Edge mode, source 0 pulsed for four cycles.
        cpu_write(2'd1, 8'h01);
        cpu_write(2'd2, 8'h01);
        irq_src_i = 4'b0001;
        tick(2);
        check_reg("edge_pend_early", 2'd0, 8'h00);
        tick(1);
        check_reg("edge_pend_set", 2'd0, 8'h01);
        check_irq("edge_irq_not_yet", 1'b1);
        tick(1);
        check_irq("edge_irq_low", 1'b0);
        check_reg("edge_active", 2'd3, 8'h80);
        irq_src_i = 4'b0000;
        tick(3);
        cpu_write(2'd0, 8'h01);
        check_irq("edge_irq_still_low", 1'b0);
        tick(1);
        check_irq("edge_irq_released", 1'b1);
        check_reg("edge_active_clear", 2'd3, 8'h00);

        // Level mode on source 1: W1C cannot clear while held.
        cpu_write(2'd2, 8'h00);
        cpu_write(2'd1, 8'h02);
        irq_src_i = 4'b0010;
        tick(4);
        check_reg("level_pend", 2'd0, 8'h02);
        cpu_write(2'd0, 8'h02);
        check_reg("level_w1c_ignored", 2'd0, 8'h02);
        check_irq("level_irq_low", 1'b0);
        irq_src_i = 4'b0000;
        tick(3);
        check_reg("level_pend_drop", 2'd0, 8'h00);
        check_irq("level_irq_lag", 1'b0);
        tick(1);
        check_irq("level_irq_high", 1'b1);

        // Priority between sources 1 and 3.
        cpu_write(2'd2, 8'h0A);
        cpu_write(2'd1, 8'h0A);
        irq_src_i = 4'b1010;
        tick(3);
        irq_src_i = 4'b0000;
        check_reg("prio_pend", 2'd0, 8'h0A);
        check_reg("prio_active_1", 2'd3, 8'h81);
        cpu_write(2'd0, 8'h02);
        check_reg("prio_active_3", 2'd3, 8'h83);
        cpu_write(2'd0, 8'h08);
        check_reg("prio_cleared", 2'd0, 8'h00);

        // Masking, then a W1C coinciding with a new edge.
        cpu_write(2'd1, 8'h00);
        cpu_write(2'd2, 8'h01);
        irq_src_i = 4'b0001;
        tick(3);
        check_reg("mask_pend", 2'd0, 8'h01);
        tick(1);
        check_irq("mask_irq_high", 1'b1);
        irq_src_i = 4'b0000;
        tick(3);
        irq_src_i = 4'b0001;
        tick(2);
        cpu_write(2'd0, 8'h01);
        check_reg("collide_set_wins", 2'd0, 8'h01);
        cpu_write(2'd1, 8'h01);
        tick(1);
        check_irq("collide_irq_low", 1'b0);
        irq_src_i = 4'b0000;
        tick(3);

        // Asynchronous reset mid-operation; source held across release.
        cpu_write(2'd2, 8'h0F);
        cpu_write(2'd1, 8'h0F);
        irq_src_i = 4'b1111;
        tick(3);
        check_reg("rst_pend_before", 2'd0, 8'h0F);
        rst_ni = 1'b0;
        #1;
        check_irq("rst_irq_high", 1'b1);
        check_reg("rst_pend", 2'd0, 8'h00);
        check_reg("rst_enable", 2'd1, 8'h00);
        check_reg("rst_mode", 2'd2, 8'h00);
        check_reg("rst_active", 2'd3, 8'h00);
        read_at(BASE + 16'd4, rv, ren);
        check8("rst_oow_en", {7'd0, ren}, 8'h00);
        check8("rst_oow_data", rv, 8'h00);
        tick(1);
        rst_ni = 1'b1;
        cpu_address_i = BASE;
        tick(2);
        check_reg("relse_pend_wait", 2'd0, 8'h00);
        cpu_write(2'd2, 8'h0F);
        check_reg("relse_level_pend", 2'd0, 8'h0F);
        irq_src_i = 4'b0000;
        tick(4);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) irq_src_i = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            if (r < 3) begin
                cpu_address_i = BASE + 16'($urandom_range(0, 3));
                data_i = 8'($urandom_range(0, 255));
                wen_ni = 1'b0;
            end else if (r < 8) begin
                cpu_address_i = BASE + 16'($urandom_range(0, 5)) - 16'd1;
                wen_ni = 1'b1;
            end else begin
                cpu_address_i = 16'($urandom_range(0, 65535));
                data_i = 8'($urandom_range(0, 255));
                wen_ni = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 399) == 0) begin
                rst_ni = 1'b0;
                #2;
                rst_ni = 1'b1;
            end
            tick(1);
        end
        wen_ni = 1'b1;
        cpu_address_i = 16'h0000;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
